keypad_scan_ctrl: RTL
=====================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter NROWS, default 4, number of keypad rows (2..8).
REQ-002 Parameter NCOLS, default 4, number of keypad columns (2..8).
REQ-003 Parameter SCAN_DIV, default 4096, int_osc cycles per column dwell period (>=4).
REQ-004 Parameter DEBOUNCE_N, default 8, consecutive dwell periods a press or release must be stable (>=1).
REQ-005 Derived KW = $clog2(NROWS*NCOLS), key code width.
REQ-006 int_osc  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 rows  input  NROWS  keypad row lines, active-low, asynchronous to int_osc.
REQ-009 cols  output  NCOLS  column drive, exactly one bit low at all times.
REQ-010 key_valid  output  1  one-cycle pulse on each accepted new press.
REQ-011 key_code  output  KW  code of the last accepted key, held between pulses.
REQ-012 hist_new  output  KW  most recent accepted key, for the right digit.
REQ-013 hist_old  output  KW  previous accepted key, for the left digit.
REQ-014 key_held  output  1  high while in HELD or RELEASE_DB.

Function
REQ-015 rows passes through a 2-flop synchronizer before any use; rows_s is the synchronized value.
REQ-016 Dwell counter counts 0..SCAN_DIV-1 and wraps; its terminal cycle is "period end"; all decisions below occur only at period end.
REQ-017 cols = ~(1 << col_idx); col_idx advances only in SCAN, wrapping NCOLS-1 -> 0.
REQ-018 key_code on accept = row_idx*NCOLS + col_idx; row_idx is the index of the single low bit of rows_s.
REQ-019 FSM states: SCAN, DEBOUNCE, HELD, RELEASE_DB.
REQ-020 SCAN: exactly one low bit in rows_s -> latch row_idx and pattern, debounce count = 1, go DEBOUNCE, column frozen; zero or more than one low bit -> advance column, stay.
REQ-021 DEBOUNCE: rows_s equals latched pattern -> count+1; count reaching DEBOUNCE_N -> accept and go HELD; pattern differs -> go SCAN, advance column, no pulse.
REQ-022 Accept (same cycle): key_valid = 1 for one cycle; key_code <= code; hist_old <= hist_new; hist_new <= code.
REQ-023 HELD: column frozen; rows_s all ones -> RELEASE_DB, count = 1; otherwise stay, no further pulses (no auto-repeat); second keys in the same column ignored.
REQ-024 RELEASE_DB: rows_s all ones -> count+1; count reaching DEBOUNCE_N -> SCAN, advance column; any low bit -> back to HELD, no pulse.
REQ-025 DEBOUNCE_N = 1: accept at the first period end with a single low bit, no extra cycle.
REQ-026 Worst-case press-to-pulse latency = 2 + (NCOLS + DEBOUNCE_N)*SCAN_DIV cycles for a clean press.
REQ-027 Counters and indices never exceed their range; no value of rows can leave cols with other than one low bit.

Reset
REQ-028 reset low asserts immediately, independent of int_osc: state = SCAN, col_idx = 0, cols = {all ones except bit 0 low}, counters = 0, synchronizer = all ones.
REQ-029 During reset key_valid = 0, key_code = 0, hist_new = 0, hist_old = 0, key_held = 0.
REQ-030 reset asserted mid-DEBOUNCE or mid-HELD aborts the operation, no pulse is produced, and history is cleared.
REQ-031 After reset release, scanning resumes at column 0 on the first int_osc edge.

Verification (NROWS=4, NCOLS=4, SCAN_DIV=4, DEBOUNCE_N=3; bench models keypad as row low only while its column is driven)
REQ-032 Clean press of row 1, col 0 -> one key_valid pulse within 2+7*4 = 30 cycles; key_code = 4, hist_new = 4, hist_old = 0; key_held = 1.
REQ-033 Hold that key 200 cycles, then release, then press row 2, col 3 -> exactly one more pulse; key_code = 11, hist_new = 11, hist_old = 4.
REQ-034 Bounce: press toggled every 3 cycles for 40 cycles, then stable -> exactly one pulse, none during bounce.
REQ-035 Two keys in one column (rows = 4'b1001) -> no pulse; cols keeps rotating 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-036 Release glitch: while HELD, rows all high for 1 period then low again -> stays held, no new pulse.
REQ-037 reset pulse low during DEBOUNCE -> no pulse; all outputs 0 and cols = 4'b1110 while reset is low.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad-side signal bundle: row sense lines in, column drive and decoded key outputs.
interface keypad_scan_if #(
  parameter int unsigned NROWS = 4,
  parameter int unsigned NCOLS = 4
);
  localparam int unsigned KW = $clog2(NROWS * NCOLS);

  logic [NROWS-1:0] rows;
  logic [NCOLS-1:0] cols;
  logic             key_valid;
  logic [KW-1:0]    key_code;
  logic [KW-1:0]    hist_new;
  logic [KW-1:0]    hist_old;
  logic             key_held;

  // Scan controller side
  modport master (
    input  rows,
    output cols, key_valid, key_code, hist_new, hist_old, key_held
  );

  // Keypad / consumer side
  modport slave (
    output rows,
    input  cols, key_valid, key_code, hist_new, hist_old, key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: rotates a single low column, debounces single-key
// presses and releases over whole dwell periods, and keeps a two-deep key history.
module keypad_scan_ctrl #(
  parameter int unsigned NROWS      = 4,
  parameter int unsigned NCOLS      = 4,
  parameter int unsigned SCAN_DIV   = 4096,
  parameter int unsigned DEBOUNCE_N = 8
) (
  input  logic          int_osc,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam int unsigned KW  = $clog2(NROWS * NCOLS);
  localparam int unsigned CIW = $clog2(NCOLS);
  localparam int unsigned RIW = $clog2(NROWS);
  localparam int unsigned DW  = $clog2(SCAN_DIV);
  localparam int unsigned CNW = $clog2(DEBOUNCE_N + 1);
  localparam int unsigned NLW = $clog2(NROWS + 1);

  localparam logic [1:0] ST_SCAN       = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [NROWS-1:0] rows_meta_q, rows_meta_d;
  logic [NROWS-1:0] rows_s_q,    rows_s_d;
  logic [DW-1:0]    div_q,       div_d;
  logic [CIW-1:0]   col_idx_q,   col_idx_d;
  logic [NCOLS-1:0] cols_q,      cols_d;
  logic [CNW-1:0]   cnt_q,       cnt_d;
  logic [NROWS-1:0] pat_q,       pat_d;
  logic             key_valid_q, key_valid_d;
  logic [KW-1:0]    key_code_q,  key_code_d;
  logic [KW-1:0]    hist_new_q,  hist_new_d;
  logic [KW-1:0]    hist_old_q,  hist_old_d;
  logic             key_held_q,  key_held_d;

  logic             period_end;
  logic [NLW-1:0]   n_low;
  logic [RIW-1:0]   row_idx;
  logic             one_low;
  logic             all_high;
  logic [CIW-1:0]   col_next;
  logic [CNW-1:0]   cnt_inc;
  logic [KW-1:0]    code;

  // Next-state, dwell timing, key decode and output computation
  always_comb begin
    state_d     = state_q;
    rows_meta_d = kp.rows;
    rows_s_d    = rows_meta_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    hist_new_d  = hist_new_q;
    hist_old_d  = hist_old_q;

    period_end = (div_q == DW'(SCAN_DIV - 1));
    div_d      = period_end ? '0 : div_q + DW'(1);

    n_low   = '0;
    row_idx = '0;
    for (int unsigned i = 0; i < NROWS; i++) begin
      if (!rows_s_q[i]) begin
        n_low   = n_low + NLW'(1);
        row_idx = RIW'(i);
      end
    end
    one_low  = (n_low == NLW'(1));
    all_high = &rows_s_q;

    col_next = (col_idx_q == CIW'(NCOLS - 1)) ? '0 : col_idx_q + CIW'(1);
    cnt_inc  = cnt_q + CNW'(1);
    code     = KW'(32'(row_idx) * NCOLS + 32'(col_idx_q));

    if (period_end) begin
      case (state_q)
        ST_SCAN: begin
          if (one_low) begin
            pat_d = rows_s_q;
            if (DEBOUNCE_N == 1) begin
              state_d     = ST_HELD;
              key_valid_d = 1'b1;
              key_code_d  = code;
              hist_old_d  = hist_new_q;
              hist_new_d  = code;
              cnt_d       = '0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNW'(1);
            end
          end else begin
            col_idx_d = col_next;
          end
        end
        ST_DEBOUNCE: begin
          if (rows_s_q == pat_q) begin
            if (cnt_inc >= CNW'(DEBOUNCE_N)) begin
              state_d     = ST_HELD;
              key_valid_d = 1'b1;
              key_code_d  = code;
              hist_old_d  = hist_new_q;
              hist_new_d  = code;
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_next;
            cnt_d     = '0;
          end
        end
        ST_HELD: begin
          if (all_high) begin
            if (DEBOUNCE_N == 1) begin
              state_d   = ST_SCAN;
              col_idx_d = col_next;
              cnt_d     = '0;
            end else begin
              state_d = ST_RELEASE_DB;
              cnt_d   = CNW'(1);
            end
          end
        end
        ST_RELEASE_DB: begin
          if (all_high) begin
            if (cnt_inc >= CNW'(DEBOUNCE_N)) begin
              state_d   = ST_SCAN;
              col_idx_d = col_next;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d   = ST_SCAN;
          col_idx_d = '0;
          cnt_d     = '0;
        end
      endcase
    end

    cols_d     = ~(NCOLS'(1) << col_idx_d);
    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_DB);
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      rows_meta_q <= '1;
      rows_s_q    <= '1;
      div_q       <= '0;
      col_idx_q   <= '0;
      cols_q      <= ~NCOLS'(1);
      cnt_q       <= '0;
      pat_q       <= '1;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      hist_new_q  <= '0;
      hist_old_q  <= '0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_meta_q <= rows_meta_d;
      rows_s_q    <= rows_s_d;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      cols_q      <= cols_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      hist_new_q  <= hist_new_d;
      hist_old_q  <= hist_old_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.hist_new  = hist_new_q;
  assign kp.hist_old  = hist_old_q;
  assign kp.key_held  = key_held_q;

endmodule
